// File: rtl/sdram_axi_pkg.sv
// Shared AXI encodings and FSM state type for the pmem-to-AXI4 initiator bridge.
package sdram_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WRESP = 2'd2,
    READ  = 2'd3
  } state_t;

  function automatic logic resp_is_error(input logic [1:0] resp);
    logic r_err;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:  r_err = 1'b0;
      RESP_SLVERR, RESP_DECERR: r_err = 1'b1;
      default:                 r_err = 1'b1;
    endcase
    return r_err;
  endfunction

endpackage

// File: rtl/sdram_pmem_axi_master_if.sv
// AXI4 master-port bundle; the bridge takes the master modport, the memory model the slave modport.
interface sdram_pmem_axi_master_if #(
  parameter int ADDR_W = 32
);

  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awid;
  logic [7:0]        awlen;
  logic [1:0]        awburst;
  logic              awready;

  logic              wvalid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wready;

  logic              bvalid;
  logic [1:0]        bresp;
  logic [3:0]        bid;
  logic              bready;

  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              arready;

  logic              rvalid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic [3:0]        rid;
  logic              rlast;
  logic              rready;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bresp, bid, output bready,
    output arvalid, araddr, arid, arlen, arburst, input arready,
    input rvalid, rdata, rresp, rid, rlast, output rready
  );

  modport slave (
    input awvalid, awaddr, awid, awlen, awburst, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready,
    input arvalid, araddr, arid, arlen, arburst, output arready,
    output rvalid, rdata, rresp, rid, rlast, input rready
  );

endinterface

// File: rtl/sdram_axi_wbuf.sv
// Single-entry W channel holding register: a loaded beat stays valid until wready takes it.
module sdram_axi_wbuf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [3:0]  i_strb,
  input  logic        i_last,
  input  logic        i_wready,
  output logic        o_wvalid,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wlast,
  output logic        o_free,
  output logic        o_last_hs
);

  logic        r_valid;
  logic [31:0] r_data;
  logic [3:0]  r_strb;
  logic        r_last;

  // A load may replace a beat that is handshaking in the same cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_strb  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_strb  <= i_strb;
      r_last  <= i_last;
    end else if (i_wready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_wvalid  = r_valid;
  assign o_wdata   = r_data;
  assign o_wstrb   = r_strb;
  assign o_wlast   = r_last;
  assign o_free    = !r_valid || i_wready;
  assign o_last_hs = r_valid && i_wready && r_last;

endmodule

// File: rtl/sdram_pmem_axi_master.sv
// pmem request interface to AXI4 INCR burst bridge, one transaction outstanding at a time.
module sdram_pmem_axi_master
  import sdram_axi_pkg::*;
#(
  parameter int AXI_ID = 0,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        inport_wr_i,
  input  logic              inport_rd_i,
  input  logic [7:0]        inport_len_i,
  input  logic [ADDR_W-1:0] inport_addr_i,
  input  logic [31:0]       inport_write_data_i,
  output logic              inport_accept_o,
  output logic              inport_ack_o,
  output logic              inport_error_o,
  output logic [31:0]       inport_read_data_o,
  sdram_pmem_axi_master_if.master axi
);

  localparam logic [3:0] ID_VAL = 4'(AXI_ID);

  state_t            r_state;
  state_t            w_next;
  logic              r_awvalid;
  logic [ADDR_W-1:0] r_awaddr;
  logic [7:0]        r_awlen;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [7:0]        r_remaining;
  logic              r_wdone;
  logic              r_ack;
  logic              r_error;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_load;
  logic              w_load_last;
  logic              w_wfree;
  logic              w_wlast_hs;
  logic              w_aw_done;
  logic [ADDR_W-1:0] w_addr_aligned;

  assign w_addr_aligned = inport_addr_i & ~ADDR_W'(3);
  assign w_aw_done      = !r_awvalid || axi.awready;

  sdram_axi_wbuf u_wbuf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_load    (w_load),
    .i_data    (inport_write_data_i),
    .i_strb    (inport_wr_i),
    .i_last    (w_load_last),
    .i_wready  (axi.wready),
    .o_wvalid  (axi.wvalid),
    .o_wdata   (axi.wdata),
    .o_wstrb   (axi.wstrb),
    .o_wlast   (axi.wlast),
    .o_free    (w_wfree),
    .o_last_hs (w_wlast_hs)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A simultaneous wr/rd in IDLE issues the write; the read waits on the input.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_load_last = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = 1'b1;
        if (inport_wr_i != 4'd0) begin
          w_load      = 1'b1;
          w_load_last = (inport_len_i == 8'd0);
          w_next      = WRITE;
        end else if (inport_rd_i) begin
          w_next = READ;
        end
      end
      WRITE: begin
        w_accept    = (r_remaining != 8'd0) && w_wfree && (inport_wr_i != 4'd0);
        w_load      = w_accept;
        w_load_last = (r_remaining == 8'd1);
        if ((r_wdone || w_wlast_hs) && w_aw_done) w_next = WRESP;
      end
      WRESP:   if (axi.bvalid) w_next = IDLE;
      READ:    if (axi.rvalid && axi.rlast) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_remaining <= '0;
      r_wdone     <= 1'b0;
      r_ack       <= 1'b0;
      r_error     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_error <= 1'b0;
      if (r_awvalid && axi.awready) r_awvalid <= 1'b0;
      if (r_arvalid && axi.arready) r_arvalid <= 1'b0;
      if (w_wlast_hs)               r_wdone   <= 1'b1;
      case (r_state)
        IDLE: begin
          if (inport_wr_i != 4'd0) begin
            r_awvalid   <= 1'b1;
            r_awaddr    <= w_addr_aligned;
            r_awlen     <= inport_len_i;
            r_remaining <= inport_len_i;
            r_wdone     <= 1'b0;
          end else if (inport_rd_i) begin
            r_arvalid <= 1'b1;
            r_araddr  <= w_addr_aligned;
            r_arlen   <= inport_len_i;
          end
        end
        WRITE: if (w_accept) r_remaining <= r_remaining - 8'd1;
        WRESP: begin
          if (axi.bvalid) begin
            r_ack   <= 1'b1;
            r_error <= resp_is_error(axi.bresp) || (axi.bid != ID_VAL);
          end
        end
        READ: begin
          if (axi.rvalid) begin
            r_ack   <= 1'b1;
            r_rdata <= axi.rdata;
            r_error <= resp_is_error(axi.rresp) || (axi.rid != ID_VAL);
          end
        end
        default: ;
      endcase
    end
  end

  assign inport_accept_o    = w_accept;
  assign inport_ack_o       = r_ack;
  assign inport_error_o     = r_error;
  assign inport_read_data_o = r_rdata;

  assign axi.awvalid = r_awvalid;
  assign axi.awaddr  = r_awaddr;
  assign axi.awid    = ID_VAL;
  assign axi.awlen   = r_awlen;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.bready  = (r_state == WRESP);
  assign axi.arvalid = r_arvalid;
  assign axi.araddr  = r_araddr;
  assign axi.arid    = ID_VAL;
  assign axi.arlen   = r_arlen;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.rready  = (r_state == READ);

endmodule

// File: tb/tb_sdram_pmem_axi_master.sv
// Directed bench for sdram_pmem_axi_master: the bench plays the AXI slave cycle by cycle.
module tb_sdram_pmem_axi_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  wr;
  logic        rd;
  logic [7:0]  len;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        accept;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  int testCount = 0;
  int failCount = 0;
  int ackCount  = 0;
  int acks0;
  logic [36:0] wBeats[$];
  logic [36:0] expBeat;
  logic [3:0]  expErrV;

  sdram_pmem_axi_master_if #(.ADDR_W(32)) axi ();

  sdram_pmem_axi_master #(.AXI_ID(0), .ADDR_W(32)) dut (
    .clk_i               (clk),
    .rst_i               (rst_n),
    .inport_wr_i         (wr),
    .inport_rd_i         (rd),
    .inport_len_i        (len),
    .inport_addr_i       (addr),
    .inport_write_data_i (wdata),
    .inport_accept_o     (accept),
    .inport_ack_o        (ack),
    .inport_error_o      (err),
    .inport_read_data_o  (rdata),
    .axi                 (axi)
  );

  always #5 clk = ~clk;

  // W beats and ack pulses are logged mid-cycle, when everything is settled.
  always @(negedge clk) begin
    if (axi.wvalid && axi.wready) wBeats.push_back({axi.wlast, axi.wstrb, axi.wdata});
    if (ack) ackCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] w, input logic r, input logic [7:0] l,
                               input logic [31:0] a, input logic [31:0] d);
    wr    = w;
    rd    = r;
    len   = l;
    addr  = a;
    wdata = d;
    #1;
  endtask

  task automatic singleWrite(input string tag, input logic [3:0] strb, input logic [31:0] a,
                             input logic [31:0] expAddr, input logic [31:0] d,
                             input logic [1:0] resp, input logic [3:0] id, input logic expErr);
    int base;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    applyStimulus(strb, 1'b0, 8'd0, a, d);
    checkOutput({tag, " accept"}, accept, 1);
    tick();
    applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
    checkOutput({tag, " awvalid"}, axi.awvalid, 1);
    checkOutput({tag, " awaddr"}, axi.awaddr, expAddr);
    checkOutput({tag, " awlen"}, axi.awlen, 0);
    checkOutput({tag, " awburst"}, axi.awburst, 2'b01);
    checkOutput({tag, " awid"}, axi.awid, 0);
    checkOutput({tag, " wvalid"}, axi.wvalid, 1);
    checkOutput({tag, " wdata"}, axi.wdata, d);
    checkOutput({tag, " wstrb"}, axi.wstrb, strb);
    checkOutput({tag, " wlast"}, axi.wlast, 1);
    tick();
    checkOutput({tag, " bready"}, axi.bready, 1);
    checkOutput({tag, " awvalid low"}, axi.awvalid, 0);
    checkOutput({tag, " wvalid low"}, axi.wvalid, 0);
    checkOutput({tag, " no early ack"}, ack, 0);
    axi.bvalid = 1'b1;
    axi.bresp  = resp;
    axi.bid    = id;
    base = ackCount;
    tick();
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    axi.bid    = 4'h0;
    checkOutput({tag, " ack"}, ack, 1);
    checkOutput({tag, " error"}, err, expErr);
    checkOutput({tag, " idle accept"}, accept, 1);
    tick();
    checkOutput({tag, " ack pulse"}, ack, 0);
    checkOutput({tag, " ack count"}, ackCount - base, 1);
  endtask

  initial begin
    wr = 4'h0; rd = 1'b0; len = 8'h0; addr = 32'h0; wdata = 32'h0;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'h0;
    axi.arready = 1'b0;
    axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00; axi.rid = 4'h0; axi.rlast = 1'b0;

    #12;
    checkOutput("reset awvalid", axi.awvalid, 0);
    checkOutput("reset wvalid", axi.wvalid, 0);
    checkOutput("reset arvalid", axi.arvalid, 0);
    checkOutput("reset bready", axi.bready, 0);
    checkOutput("reset rready", axi.rready, 0);
    checkOutput("reset ack", ack, 0);
    checkOutput("reset error", err, 0);
    checkOutput("reset rdata", rdata, 0);
    checkOutput("reset wdata", axi.wdata, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("post reset accept", accept, 1);

    singleWrite("w1", 4'hF, 32'h0000_1000, 32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 4'h0, 1'b0);

    // 4-beat write: beat 2 stalls three cycles on wready, AW is held back until after W.
    wBeats.delete();
    acks0 = ackCount;
    axi.awready = 1'b0;
    axi.wready  = 1'b1;
    applyStimulus(4'hF, 1'b0, 8'd3, 32'h0000_3000, 32'h0000_00A0);
    tick();
    checkOutput("w4 awlen", axi.awlen, 3);
    checkOutput("w4 awaddr", axi.awaddr, 32'h0000_3000);
    checkOutput("w4 beat0 wlast", axi.wlast, 0);
    applyStimulus(4'hF, 1'b0, 8'd3, 32'h0000_3000, 32'h0000_00A1);
    checkOutput("w4 accept beat1", accept, 1);
    tick();
    applyStimulus(4'hF, 1'b0, 8'd3, 32'h0000_3000, 32'h0000_00A2);
    tick();
    axi.wready = 1'b0;
    applyStimulus(4'hF, 1'b0, 8'd3, 32'h0000_3000, 32'h0000_00A3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("w4 stall accept", accept, 0);
      checkOutput("w4 stall wdata", axi.wdata, 32'h0000_00A2);
      tick();
    end
    axi.wready = 1'b1;
    #1;
    checkOutput("w4 resume accept", accept, 1);
    tick();
    checkOutput("w4 beat3 wdata", axi.wdata, 32'h0000_00A3);
    checkOutput("w4 beat3 wlast", axi.wlast, 1);
    checkOutput("w4 no accept past len", accept, 0);
    applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
    tick();
    checkOutput("w4 w drained", axi.wvalid, 0);
    checkOutput("w4 aw still pending", axi.awvalid, 1);
    checkOutput("w4 waits for aw", axi.bready, 0);
    axi.awready = 1'b1;
    tick();
    checkOutput("w4 aw done", axi.awvalid, 0);
    checkOutput("w4 bready", axi.bready, 1);
    axi.bvalid = 1'b1;
    tick();
    axi.bvalid = 1'b0;
    checkOutput("w4 ack", ack, 1);
    checkOutput("w4 error", err, 0);
    tick();
    checkOutput("w4 ack count", ackCount - acks0, 1);
    checkOutput("w4 beat count", wBeats.size(), 4);
    for (int i = 0; i < 4; i++) begin
      expBeat = {(i == 3) ? 1'b1 : 1'b0, 4'hF, 32'h0000_00A0 + 32'(i)};
      if (i < wBeats.size()) checkOutput("w4 beat order", wBeats[i], expBeat);
    end

    // 8-beat read at 0x2004 with a gap after every odd beat.
    acks0 = ackCount;
    axi.arready = 1'b0;
    applyStimulus(4'h0, 1'b1, 8'd7, 32'h0000_2004, 32'h0);
    checkOutput("rd idle accept", accept, 1);
    tick();
    applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
    checkOutput("rd arvalid", axi.arvalid, 1);
    checkOutput("rd araddr", axi.araddr, 32'h0000_2004);
    checkOutput("rd arlen", axi.arlen, 7);
    checkOutput("rd arburst", axi.arburst, 2'b01);
    checkOutput("rd arid", axi.arid, 0);
    checkOutput("rd rready", axi.rready, 1);
    checkOutput("rd accept low", accept, 0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    checkOutput("rd arvalid drop", axi.arvalid, 0);
    for (int i = 0; i < 8; i++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = 32'(i);
      axi.rlast  = (i == 7);
      tick();
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      checkOutput("rd ack", ack, 1);
      checkOutput("rd data", rdata, i);
      checkOutput("rd error", err, 0);
      if ((i % 2 == 1) && (i != 7)) begin
        tick();
        checkOutput("rd gap no ack", ack, 0);
        checkOutput("rd data held", rdata, i);
      end
    end
    checkOutput("rd back to idle", accept, 1);
    checkOutput("rd rready off", axi.rready, 0);
    tick();
    checkOutput("rd ack count", ackCount - acks0, 8);

    singleWrite("slverr", 4'hF, 32'h0000_1100, 32'h0000_1100, 32'h0000_0001, 2'b10, 4'h0, 1'b1);
    singleWrite("bid", 4'hF, 32'h0000_1203, 32'h0000_1200, 32'h0000_0002, 2'b00, 4'h5, 1'b1);

    // 4-beat read: DECERR on beat 2, foreign RID on beat 3.
    expErrV = 4'b1100;
    axi.arready = 1'b1;
    applyStimulus(4'h0, 1'b1, 8'd3, 32'h0000_6000, 32'h0);
    tick();
    applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
    tick();
    axi.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = 32'h0000_0100 + 32'(i);
      axi.rresp  = (i == 2) ? 2'b11 : 2'b00;
      axi.rid    = (i == 3) ? 4'h1 : 4'h0;
      axi.rlast  = (i == 3);
      tick();
      checkOutput("rderr ack", ack, 1);
      checkOutput("rderr data", rdata, 32'h0000_0100 + 32'(i));
      checkOutput("rderr error", err, expErrV[i]);
    end
    axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rid = 4'h0; axi.rlast = 1'b0;
    tick();
    checkOutput("rderr ack done", ack, 0);

    // Write and read together: write first, read issued after the B response.
    acks0 = ackCount;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    applyStimulus(4'h3, 1'b1, 8'd0, 32'h0000_4000, 32'h1234_5678);
    checkOutput("wr+rd accept", accept, 1);
    tick();
    applyStimulus(4'h0, 1'b1, 8'd0, 32'h0000_4000, 32'h0);
    checkOutput("wr+rd awvalid", axi.awvalid, 1);
    checkOutput("wr+rd wstrb", axi.wstrb, 4'h3);
    checkOutput("wr+rd wdata", axi.wdata, 32'h1234_5678);
    checkOutput("wr+rd no ar yet", axi.arvalid, 0);
    tick();
    checkOutput("wr+rd bready", axi.bready, 1);
    checkOutput("wr+rd still no ar", axi.arvalid, 0);
    axi.bvalid = 1'b1;
    tick();
    axi.bvalid = 1'b0;
    checkOutput("wr+rd write ack", ack, 1);
    checkOutput("wr+rd ar after b", axi.arvalid, 0);
    tick();
    applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
    checkOutput("wr+rd arvalid", axi.arvalid, 1);
    checkOutput("wr+rd araddr", axi.araddr, 32'h0000_4000);
    checkOutput("wr+rd arlen", axi.arlen, 0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 32'h0000_0055; axi.rlast = 1'b1;
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    checkOutput("wr+rd read ack", ack, 1);
    checkOutput("wr+rd read data", rdata, 32'h0000_0055);
    tick();
    checkOutput("wr+rd ack count", ackCount - acks0, 2);

    // Asynchronous reset while beat 3 of an 8-beat read is on the bus.
    axi.arready = 1'b1;
    applyStimulus(4'h0, 1'b1, 8'd7, 32'h0000_5000, 32'h0);
    tick();
    applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
    tick();
    axi.arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = 32'h0000_0070 + 32'(i);
      tick();
    end
    axi.rdata = 32'h0000_0073;
    checkOutput("rst pre ack", ack, 1);
    checkOutput("rst pre data", rdata, 32'h0000_0072);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst ack", ack, 0);
    checkOutput("rst arvalid", axi.arvalid, 0);
    checkOutput("rst awvalid", axi.awvalid, 0);
    checkOutput("rst wvalid", axi.wvalid, 0);
    checkOutput("rst rready", axi.rready, 0);
    checkOutput("rst bready", axi.bready, 0);
    checkOutput("rst rdata", rdata, 0);
    axi.rvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rst release accept", accept, 1);
    tick();
    checkOutput("rst no stray ack", ack, 0);
    checkOutput("rst still idle", axi.rready, 0);

    singleWrite("post-rst", 4'hC, 32'h0000_7000, 32'h0000_7000, 32'hCAFE_F00D, 2'b01, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
